// File: rtl/ofmap_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ofmap_packer                                                       |
// | Purpose : packs 1-8 ofmap pixels per beat into dense 64-bit DRAM words,      |
// |           zero-pads the layer's final word, flags it, then pulses layerDone. |
// |           Optional running XOR checksum when PACK_CHECKSUM_EN is defined.    |
// | Revision: 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module ofmap_packer #(
  parameter int PIX_W     = 8,
  parameter int MODE0_PIX = 676,
  parameter int MODE1_PIX = 169
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [2:0]  mode,
  input  logic        pixValid,
  input  logic [63:0] pixIn,
  input  logic [3:0]  pixCount,
  output logic        pixReady,
  output logic        outValid,
  output logic [63:0] dataOut,
  output logic        outLast,
  input  logic        dramReady,
  output logic [10:0] wordAddr,
  output logic [10:0] totalPix,
  output logic        layerDone,
  output logic [63:0] checksum
);

  localparam logic [1:0] ST_PACK  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [10:0] C_MODE0_PIX = 11'(MODE0_PIX);
  localparam logic [10:0] C_MODE1_PIX = 11'(MODE1_PIX);

  logic [127:0] pbuf_q, pbuf_d;
  logic [7:0]   idx_q, idx_d;
  logic [10:0]  total_q, total_d;
  logic [10:0]  addr_q, addr_d;
  logic [1:0]   state_q, state_d;
  logic         mode_q, mode_d;

  logic [10:0]  layer_pix;
  logic [10:0]  remaining;
  logic [3:0]   cnt_clamped;
  logic [3:0]   eff;
  logic         accept;
  logic         pop;
  logic [63:0]  out_mask;
  logic [63:0]  in_mask;
  logic [127:0] base_buf;
  logic [7:0]   base_idx;

  always_comb begin
    // The first beat of a layer decides its size; afterwards the latched mode rules.
    if (total_q == 11'd0) layer_pix = mode[0] ? C_MODE1_PIX : C_MODE0_PIX;
    else                  layer_pix = mode_q  ? C_MODE1_PIX : C_MODE0_PIX;
    remaining   = layer_pix - total_q;
    cnt_clamped = (pixCount > 4'd8) ? 4'd8 : pixCount;
    eff         = ({7'd0, cnt_clamped} > remaining) ? remaining[3:0] : cnt_clamped;

    pixReady  = (state_q == ST_PACK) && (idx_q <= 8'd64) && (mode < 3'd2);
    accept    = pixValid && pixReady && (pixCount != 4'd0);
    outValid  = ((state_q == ST_PACK)  && (idx_q >= 8'd64)) ||
                ((state_q == ST_FLUSH) && (idx_q != 8'd0));
    outLast   = (state_q == ST_FLUSH) && (idx_q != 8'd0) && (idx_q <= 8'd64);
    layerDone = (state_q == ST_DONE);

    for (int k = 0; k < 8; k++) begin
      out_mask[k*PIX_W +: PIX_W] = (idx_q > 8'(k*PIX_W)) ? '1 : '0;
      in_mask[k*PIX_W +: PIX_W]  = (4'(k) < eff)        ? '1 : '0;
    end
    dataOut = pbuf_q[63:0] & out_mask;
    pop     = outValid && dramReady;

    wordAddr = addr_q;
    totalPix = total_q;
  end

  always_comb begin
    pbuf_d  = pbuf_q;
    idx_d   = idx_q;
    total_d = total_q;
    addr_d  = addr_q;
    state_d = state_q;
    mode_d  = mode_q;

    if (pop) begin
      base_buf = pbuf_q >> 64;
      base_idx = (idx_q >= 8'd64) ? (idx_q - 8'd64) : 8'd0;
      addr_d   = addr_q + 11'd1;
    end else begin
      base_buf = pbuf_q;
      base_idx = idx_q;
    end
    pbuf_d = base_buf;
    idx_d  = base_idx;

    // New pixels append above whatever survives this cycle's pop.
    if (accept) begin
      pbuf_d  = base_buf | ({64'd0, pixIn & in_mask} << base_idx);
      idx_d   = base_idx + {1'b0, eff, 3'b000};
      total_d = total_q + {7'd0, eff};
      if (total_q == 11'd0) mode_d = mode[0];
      if ((total_q + {7'd0, eff}) == layer_pix) state_d = ST_FLUSH;
    end

    case (state_q)
      ST_FLUSH: if (pop && outLast) state_d = ST_DONE;
      ST_DONE: begin
        pbuf_d  = '0;
        idx_d   = '0;
        total_d = '0;
        addr_d  = '0;
        mode_d  = 1'b0;
        state_d = ST_PACK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      pbuf_q  <= '0;
      idx_q   <= '0;
      total_q <= '0;
      addr_q  <= '0;
      state_q <= ST_PACK;
      mode_q  <= 1'b0;
    end else begin
      pbuf_q  <= pbuf_d;
      idx_q   <= idx_d;
      total_q <= total_d;
      addr_q  <= addr_d;
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

`ifdef PACK_CHECKSUM_EN
  logic [63:0] chk_q, chk_d;

  // Held through the DONE cycle so the consumer can sample it alongside layerDone.
  always_comb begin
    chk_d = chk_q;
    if (state_q == ST_DONE) chk_d = '0;
    else if (pop)           chk_d = chk_q ^ dataOut;
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) chk_q <= '0;
    else               chk_q <= chk_d;
  end

  assign checksum = chk_q;
`else
  assign checksum = 64'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ofmap_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ofmap_packer                                                    |
// | Purpose : scoreboard bench for ofmap_packer (directed layers, backpressure,  |
// |           clear abort, truncated final beats).                               |
// | Revision: 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module tb_ofmap_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic        pixValid = 1'b0;
  logic [63:0] pixIn = '0;
  logic [3:0]  pixCount = '0;
  logic        pixReady;
  logic        outValid;
  logic [63:0] dataOut;
  logic        outLast;
  logic        dramReady = 1'b1;
  logic [10:0] wordAddr;
  logic [10:0] totalPix;
  logic        layerDone;
  logic [63:0] checksum;

  ofmap_packer dut (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode),
    .pixValid(pixValid), .pixIn(pixIn), .pixCount(pixCount), .pixReady(pixReady),
    .outValid(outValid), .dataOut(dataOut), .outLast(outLast), .dramReady(dramReady),
    .wordAddr(wordAddr), .totalPix(totalPix), .layerDone(layerDone), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic        last;
    logic [10:0] a;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] cap[$];
  logic [7:0]  pend[$];
  int          m_tot = 0;
  int          m_addr = 0;
  int          m_layer_pix = 676;
  logic [63:0] chk_acc = '0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_hs = -10;
  int          done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic void push_word(input bit last);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++)
      if (k < pend.size()) w[8*k +: 8] = pend[k];
    pend.delete();
    exp_q.push_back('{w, last, 11'(m_addr)});
    m_addr++;
    if (last) begin
      m_addr = 0;
      m_tot  = 0;
    end
  endfunction

  function automatic void model_accept(input int cnt, input logic [63:0] d);
    int eff;
    eff = (cnt > m_layer_pix - m_tot) ? (m_layer_pix - m_tot) : cnt;
    for (int k = 0; k < eff; k++) begin
      pend.push_back(d[8*k +: 8]);
      m_tot++;
      if (pend.size() == 8) push_word(m_tot == m_layer_pix);
    end
    if (m_tot == m_layer_pix && pend.size() > 0) push_word(1'b1);
  endfunction

  function automatic logic [63:0] mk(input int base, input int cnt);
    logic [63:0] d;
    for (int k = 0; k < 8; k++)
      d[8*k +: 8] = (k < cnt) ? 8'(base + k) : 8'hEE;
    return d;
  endfunction

  task automatic send_beat(input int cnt, input logic [63:0] d);
    int t;
    t = 0;
    pixValid = 1'b1;
    pixCount = 4'(cnt);
    pixIn    = d;
    while (1) begin
      @(negedge clk);
      if (pixReady) break;
      t++;
      if (t > 400) begin
        chk("beat_timeout", 64'(pixReady), 64'd1);
        break;
      end
    end
    if (pixReady) model_accept(cnt, d);
    @(posedge clk); #1;
    pixValid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("layer_done_seen", 64'(done_cnt), 64'(target));
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: pops one expectation per DRAM handshake.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      if (outValid && dramReady) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected_word: got %h expected none", dataOut);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", dataOut, e.d);
          chk("sb_last", 64'(outLast), 64'(e.last));
          chk("sb_addr", 64'(wordAddr), 64'(e.a));
        end
        cap.push_back(dataOut);
        chk_acc = chk_acc ^ dataOut;
        if (outLast) last_hs = cyc;
      end
      if (layerDone) begin
        done_cnt++;
        chk("done_timing", 64'(cyc - last_hs), 64'd1);
        chk("done_outvalid", 64'(outValid), 64'd0);
`ifdef PACK_CHECKSUM_EN
        chk("checksum", checksum, chk_acc);
`else
        chk("checksum_tied", checksum, 64'd0);
`endif
        chk_acc = '0;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_outValid", 64'(outValid), 64'd0);
    chk("rst_outLast", 64'(outLast), 64'd0);
    chk("rst_layerDone", 64'(layerDone), 64'd0);
    chk("rst_totalPix", 64'(totalPix), 64'd0);
    chk("rst_wordAddr", 64'(wordAddr), 64'd0);
    chk("rst_checksum", checksum, 64'd0);
    chk("rst_pixReady", 64'(pixReady), 64'd1);
    @(posedge clk); #1;

    // Mode 0: 85 full beats, final beat truncated to 4 pixels.
    mode = 3'd0; m_layer_pix = 676; cap.delete();
    for (int b = 0; b < 85; b++) send_beat(8, mk(8 * b, 8));
    wait_done(1);
    chk("m0_words", 64'(cap.size()), 64'd85);
    chk("m0_word0", cap[0], 64'h0706050403020100);
    chk("m0_word84", cap[84], 64'h00000000A3A2A1A0);

    // Clear mid-layer with 72 bits buffered.
    dramReady = 1'b0; mode = 3'd0; m_layer_pix = 676;
    send_beat(8, mk(0, 8));
    send_beat(1, mk(8, 1));
    chk("clr_pre_outValid", 64'(outValid), 64'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_outValid", 64'(outValid), 64'd0);
    chk("clr_totalPix", 64'(totalPix), 64'd0);
    chk("clr_wordAddr", 64'(wordAddr), 64'd0);
    exp_q.delete(); pend.delete(); m_tot = 0; m_addr = 0; chk_acc = '0;
    dramReady = 1'b1;

    // Mode 1: 3-pixel beats, last beat keeps one pixel.
    mode = 3'd1; m_layer_pix = 169; cap.delete();
    for (int b = 0; b < 57; b++) send_beat(3, mk(3 * b + 1, 3));
    chk("m1_totalPix_flush", 64'(totalPix), 64'd169);
    chk("m1_pixReady_flush", 64'(pixReady), 64'd0);
    wait_done(2);
    chk("m1_words", 64'(cap.size()), 64'd22);
    chk("m1_word0", cap[0], 64'h0807060504030201);
    chk("m1_word21", cap[21], 64'h00000000000000A9);

    // Backpressure: DRAM stalled for 20 cycles while beats keep coming.
    mode = 3'd1; m_layer_pix = 169; cap.delete(); dramReady = 1'b0;
    fork
      begin
        for (int b = 0; b < 21; b++) send_beat(8, mk(64 + 8 * b, 8));
        send_beat(1, mk(64 + 168, 1));
      end
      begin
        logic [63:0] d5;
        repeat (5) @(negedge clk);
        d5 = dataOut;
        repeat (10) @(negedge clk);
        chk("bp_pixReady", 64'(pixReady), 64'd0);
        chk("bp_outValid", 64'(outValid), 64'd1);
        chk("bp_stable", dataOut, d5);
        chk("bp_word0", dataOut, 64'h4746454443424140);
        repeat (5) @(posedge clk);
        #1 dramReady = 1'b1;
      end
    join
    wait_done(3);
    chk("bp_words", 64'(cap.size()), 64'd22);
    chk("bp_word21", cap[21], 64'h00000000000000E8);

    // Mode 1 with 8-pixel final beat and one pixel left; mode flips mid-layer.
    mode = 3'd1; m_layer_pix = 169; cap.delete();
    for (int b = 0; b < 21; b++) begin
      if (b == 10) mode = 3'd0;
      send_beat(8, mk(8 * b, 8));
    end
    send_beat(8, 64'hFFEEDDCCBBAA9988);
    chk("tr_totalPix", 64'(totalPix), 64'd169);
    wait_done(4);
    chk("tr_words", 64'(cap.size()), 64'd22);
    chk("tr_word21", cap[21], 64'h0000000000000088);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
